// File: rtl/spi_frame_engine.sv
// SPI peripheral frame engine: command byte + data byte(s) to register strobes, read data out on MISO.
// Optional macro SPI_AUTOINC_EN enables burst transfers with auto-incrementing register address.
module spi_frame_engine #(
   parameter int ADDR_WIDTH = 3,
   parameter int REG_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ena,
   input  logic [1:0]            mode,
   input  logic                  spi_cs_n,
   input  logic                  spi_clk,
   input  logic                  spi_mosi,
   output logic                  spi_miso,
   output logic [ADDR_WIDTH-1:0] reg_addr,
   output logic                  wr_en,
   output logic [REG_WIDTH-1:0]  wr_data,
   output logic                  rd_req,
   input  logic [REG_WIDTH-1:0]  rd_data
);

   typedef enum logic [1:0] {
      IDLE,
      CMD,
      DATA,
      DONE
   } state_t;

   state_t               state;
   logic                 sclk_d;
   logic                 cs_d;
   logic                 cpol_q;
   logic                 cpha_q;
   logic                 w_q;
   logic                 load_pend;
   logic [2:0]           bit_cnt;
   logic [REG_WIDTH-2:0] rx_sr;
   logic [REG_WIDTH-1:0] tx_sr;
   logic [REG_WIDTH-1:0] rd_hold;

   logic                 sclk_rise;
   logic                 sclk_fall;
   logic                 lead_edge;
   logic                 trail_edge;
   logic                 sample_edge;
   logic                 shift_edge;
   logic                 cs_fall;
   logic                 byte_done;
   logic [REG_WIDTH-1:0] rx_byte;

   assign sclk_rise   = spi_clk & ~sclk_d;
   assign sclk_fall   = ~spi_clk & sclk_d;
   assign lead_edge   = cpol_q ? sclk_fall : sclk_rise;
   assign trail_edge  = cpol_q ? sclk_rise : sclk_fall;
   assign sample_edge = cpha_q ? trail_edge : lead_edge;
   assign shift_edge  = cpha_q ? lead_edge : trail_edge;
   // cs_d resets low so a select already asserted across reset is not taken as a new frame
   assign cs_fall     = cs_d & ~spi_cs_n;
   assign byte_done   = sample_edge && (bit_cnt == 3'd7);
   assign rx_byte     = {rx_sr, spi_mosi};
   assign spi_miso    = tx_sr[REG_WIDTH-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         sclk_d    <= 1'b0;
         cs_d      <= 1'b0;
         cpol_q    <= 1'b0;
         cpha_q    <= 1'b0;
         w_q       <= 1'b0;
         load_pend <= 1'b0;
         bit_cnt   <= '0;
         rx_sr     <= '0;
         tx_sr     <= '0;
         rd_hold   <= '0;
         reg_addr  <= '0;
         wr_en     <= 1'b0;
         wr_data   <= '0;
         rd_req    <= 1'b0;
      end else if (ena) begin
         sclk_d <= spi_clk;
         cs_d   <= spi_cs_n;
         // NOTE: strobes default low every enabled cycle so each pulse lasts exactly one clk.
         wr_en  <= 1'b0;
         rd_req <= 1'b0;

         // rd_data is valid while rd_req is high, i.e. one cycle after the address update
         if (rd_req)
            rd_hold <= rd_data;

         if (state == IDLE) begin
            cpol_q <= mode[1];
            cpha_q <= mode[0];
         end

         if (spi_cs_n) begin
            state <= IDLE;
         end else begin
            case (state)
               IDLE: begin
                  if (cs_fall) begin
                     state     <= CMD;
                     bit_cnt   <= '0;
                     tx_sr     <= '0;
                     load_pend <= 1'b0;
                  end
               end

               CMD: begin
                  if (shift_edge)
                     tx_sr <= {tx_sr[REG_WIDTH-2:0], 1'b0};
                  if (sample_edge) begin
                     rx_sr   <= rx_byte[REG_WIDTH-2:0];
                     bit_cnt <= bit_cnt + 3'd1;
                     if (byte_done) begin
                        reg_addr  <= rx_byte[ADDR_WIDTH-1:0];
                        w_q       <= rx_byte[REG_WIDTH-1];
                        rd_req    <= ~rx_byte[REG_WIDTH-1];
                        load_pend <= 1'b1;
                        state     <= DATA;
                     end
                  end
               end

               DATA: begin
                  // first shift edge of a byte presents the read data; write frames send zeros
                  if (shift_edge) begin
                     if (load_pend) begin
                        tx_sr     <= w_q ? '0 : rd_hold;
                        load_pend <= 1'b0;
                     end else begin
                        tx_sr <= {tx_sr[REG_WIDTH-2:0], 1'b0};
                     end
                  end
`ifdef SPI_AUTOINC_EN
                  // writes advance the address after the strobe cycle so wr_en sees the old one
                  if (wr_en)
                     reg_addr <= reg_addr + ADDR_WIDTH'(1);
`endif
                  if (sample_edge) begin
                     rx_sr   <= rx_byte[REG_WIDTH-2:0];
                     bit_cnt <= bit_cnt + 3'd1;
                     if (byte_done) begin
`ifdef SPI_AUTOINC_EN
                        if (w_q) begin
                           wr_en   <= 1'b1;
                           wr_data <= rx_byte;
                        end else begin
                           reg_addr <= reg_addr + ADDR_WIDTH'(1);
                           rd_req   <= 1'b1;
                        end
                        load_pend <= 1'b1;
`else
                        if (w_q) begin
                           wr_en   <= 1'b1;
                           wr_data <= rx_byte;
                        end
                        tx_sr <= '0;
                        state <= DONE;
`endif
                     end
                  end
               end

               DONE: begin
               end

               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_frame_engine.sv
// Self-checking bench for spi_frame_engine: directed and random SPI frames against a register-bank model.
// Honours SPI_AUTOINC_EN the same way as the design.
module tb_spi_frame_engine;

   localparam int AW = 3;
   localparam int RW = 8;
   localparam int H  = 5;
`ifdef SPI_AUTOINC_EN
   localparam bit AUTOINC = 1'b1;
`else
   localparam bit AUTOINC = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          ena;
   logic [1:0]    mode;
   logic          spi_cs_n;
   logic          spi_clk;
   logic          spi_mosi;
   logic          spi_miso;
   logic [AW-1:0] reg_addr;
   logic          wr_en;
   logic [RW-1:0] wr_data;
   logic          rd_req;
   logic [RW-1:0] rd_data;

   logic [7:0]    bank      [8];
   logic [7:0]    model_mem [8];
   logic [AW-1:0] wr_addr_q [$];
   logic [7:0]    wr_data_q [$];
   logic [AW-1:0] rd_addr_q [$];

   int total = 0;
   int bad   = 0;

   spi_frame_engine #(.ADDR_WIDTH(AW), .REG_WIDTH(RW)) dut (
      .clk      (clk),
      .rst      (rst),
      .ena      (ena),
      .mode     (mode),
      .spi_cs_n (spi_cs_n),
      .spi_clk  (spi_clk),
      .spi_mosi (spi_mosi),
      .spi_miso (spi_miso),
      .reg_addr (reg_addr),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .rd_req   (rd_req),
      .rd_data  (rd_data)
   );

   always #5 clk = ~clk;

   // register bank: combinational read, write applied on the strobe
   assign rd_data = bank[reg_addr];

   always @(negedge clk) begin
      if (wr_en) begin
         wr_addr_q.push_back(reg_addr);
         wr_data_q.push_back(wr_data);
         bank[reg_addr] = wr_data;
      end
      if (rd_req)
         rd_addr_q.push_back(reg_addr);
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_miso"},    32'(spi_miso), 32'd0);
      chk({tag, "_wr_en"},   32'(wr_en),    32'd0);
      chk({tag, "_rd_req"},  32'(rd_req),   32'd0);
      chk({tag, "_addr"},    32'(reg_addr), 32'd0);
      chk({tag, "_wr_data"}, 32'(wr_data),  32'd0);
   endtask

   // Drives nbits of frame (MSB first) as an SPI master in mode m; returns MISO captured at sample points.
   task automatic run_frame(input logic [1:0] m, input int nbits, input logic [23:0] frame,
                            input int rst_at, output logic [23:0] mrx);
      logic cpol;
      logic cpha;
      cpol = m[1];
      cpha = m[0];
      mrx  = '0;
      wr_addr_q.delete();
      wr_data_q.delete();
      rd_addr_q.delete();
      mode     = m;
      spi_clk  = cpol;
      spi_cs_n = 1'b1;
      tick(4);
      spi_cs_n = 1'b0;
      tick(2);
      mode = 2'($urandom);
      tick(2);
      for (int i = 0; i < nbits; i++) begin
         if (!cpha) begin
            spi_mosi = frame[23-i];
            tick(H);
            mrx[23-i] = spi_miso;
            spi_clk   = ~cpol;
            tick(H);
            spi_clk   = cpol;
         end else begin
            tick(H);
            spi_clk  = ~cpol;
            spi_mosi = frame[23-i];
            tick(H);
            mrx[23-i] = spi_miso;
            spi_clk   = cpol;
         end
         if (i + 1 == rst_at) begin
            tick(H);
            rst = 1'b1;
            tick(1);
            chk_reset_outputs("midrst");
            rst = 1'b0;
         end
      end
      tick(H);
      spi_cs_n = 1'b1;
      tick(4);
   endtask

   // Reference: decode frame from the protocol rules and compare strobes and MISO bytes.
   task automatic check_frame(input string tag, input int nbits, input logic [23:0] frame,
                              input logic [23:0] mrx, input bit quiet);
      logic [7:0] cmd;
      logic       w;
      int         a;
      int         k;
      int         ndata;
      int         nrd;
      logic [7:0] db;
      logic [7:0] exp_b;
      logic [7:0] got_b;
      cmd   = frame[23:16];
      w     = cmd[7];
      a     = int'(cmd[AW-1:0]);
      k     = (nbits - 8) / 8;
      ndata = AUTOINC ? k : ((k > 0) ? 1 : 0);
      if (quiet) begin
         chk({tag, "_wr_cnt"}, 32'(wr_addr_q.size()), 32'd0);
         chk({tag, "_rd_cnt"}, 32'(rd_addr_q.size()), 32'd0);
         return;
      end
      if (w) begin
         chk({tag, "_wr_cnt"}, 32'(wr_addr_q.size()), 32'(ndata));
         for (int i = 0; i < ndata; i++) begin
            db = (i == 0) ? frame[15:8] : frame[7:0];
            chk({tag, "_wr_addr"}, (i < wr_addr_q.size()) ? 32'(wr_addr_q[i]) : 32'hxxxxxxxx,
                32'((a + i) % 8));
            chk({tag, "_wr_data"}, (i < wr_data_q.size()) ? 32'(wr_data_q[i]) : 32'hxxxxxxxx,
                32'(db));
            model_mem[(a + i) % 8] = db;
         end
         chk({tag, "_rd_cnt"}, 32'(rd_addr_q.size()), 32'd0);
      end else begin
         nrd = AUTOINC ? 1 + k : 1;
         chk({tag, "_rd_cnt"}, 32'(rd_addr_q.size()), 32'(nrd));
         for (int i = 0; i < nrd; i++)
            chk({tag, "_rd_addr"}, (i < rd_addr_q.size()) ? 32'(rd_addr_q[i]) : 32'hxxxxxxxx,
                32'((a + i) % 8));
         chk({tag, "_wr_cnt"}, 32'(wr_addr_q.size()), 32'd0);
      end
      chk({tag, "_miso_cmd"}, 32'(mrx[23:16]), 32'd0);
      for (int j = 0; j < k; j++) begin
         exp_b = (!w && j < ndata) ? model_mem[(a + j) % 8] : 8'h00;
         got_b = (j == 0) ? mrx[15:8] : mrx[7:0];
         chk({tag, "_miso_data"}, 32'(got_b), 32'(exp_b));
      end
   endtask

   initial begin
      logic [23:0] mrx;
      logic [23:0] frame;
      logic [1:0]  m;
      int          nbits;
      int          sel;

      for (int i = 0; i < 8; i++) begin
         bank[i]      = 8'($urandom);
         model_mem[i] = bank[i];
      end
      rst      = 1'b1;
      ena      = 1'b1;
      mode     = 2'd0;
      spi_cs_n = 1'b1;
      spi_clk  = 1'b0;
      spi_mosi = 1'b0;
      tick(3);
      chk_reset_outputs("reset");
      rst = 1'b0;
      tick(2);

      // mode 0 write 0x83, 0x5A
      run_frame(2'd0, 16, 24'h835A00, -1, mrx);
      check_frame("m0_write", 16, 24'h835A00, mrx, 1'b0);

      // mode 3 read of address 0 holding 0xCA
      bank[0]      = 8'hCA;
      model_mem[0] = 8'hCA;
      run_frame(2'd3, 16, 24'h000000, -1, mrx);
      check_frame("m3_read", 16, 24'h000000, mrx, 1'b0);

      // modes 1 and 2: write then read back in the other mode
      for (int mm = 1; mm <= 2; mm++) begin
         run_frame(2'(mm), 16, 24'h85A500, -1, mrx);
         check_frame("m12_write", 16, 24'h85A500, mrx, 1'b0);
         run_frame(2'(3 - mm), 16, 24'h050000, -1, mrx);
         check_frame("m12_read", 16, 24'h050000, mrx, 1'b0);
      end

      // abort after 12 bits, then a normal read of the same address
      run_frame(2'($urandom), 12, 24'h82FF00, -1, mrx);
      check_frame("abort", 12, 24'h82FF00, mrx, 1'b0);
      run_frame(2'd0, 16, 24'h020000, -1, mrx);
      check_frame("post_abort", 16, 24'h020000, mrx, 1'b0);

      // reset after 10 bits of a write: no strobe, then the next frame decodes normally
      run_frame(2'd0, 16, 24'h853C00, 10, mrx);
      check_frame("rst_frame", 16, 24'h853C00, mrx, 1'b1);
      run_frame(2'd1, 16, 24'h050000, -1, mrx);
      check_frame("post_rst", 16, 24'h050000, mrx, 1'b0);

      // frame arriving while disabled is lost
      ena = 1'b0;
      run_frame(2'd0, 16, 24'h817700, -1, mrx);
      check_frame("ena_off", 16, 24'h817700, mrx, 1'b1);
      ena = 1'b1;
      tick(2);
      run_frame(2'd2, 16, 24'h010000, -1, mrx);
      check_frame("ena_on", 16, 24'h010000, mrx, 1'b0);

      // burst: two data bytes starting at the top address
      run_frame(2'd0, 24, 24'h871122, -1, mrx);
      check_frame("burst_write", 24, 24'h871122, mrx, 1'b0);
      run_frame(2'd3, 24, 24'h070000, -1, mrx);
      check_frame("burst_read", 24, 24'h070000, mrx, 1'b0);

      // random frames
      for (int it = 0; it < 16; it++) begin
         m     = 2'($urandom);
         frame = 24'($urandom);
         sel   = int'($urandom_range(0, 2));
         nbits = (sel == 0) ? 12 : ((sel == 1) ? 16 : 24);
         run_frame(m, nbits, frame, -1, mrx);
         check_frame("random", nbits, frame, mrx, 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
